// File: rtl/tmds_decoder_align.sv
// TMDS receive channel: finds the 10-bit word boundary by hunting control tokens, then decodes symbols.
// Optional feature macro: TMDS_DECODER_RELOCK_COUNT_EN adds a saturating relock_count output.
module tmds_decoder_align #(
    parameter int C_run    = 16,
    parameter int C_window = 2048
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds_raw,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       blank,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
    ,
    output logic [7:0] relock_count
`endif
);

    localparam int RUN_W = $clog2(C_run + 1);
    localparam int WIN_W = $clog2(C_window);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(C_run);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(C_run - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_window - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [9:0]       raw_reg;
    logic [9:0]       prev_raw;
    logic [19:0]      sel_buf;
    logic [9:0]       aligned;
    logic             is_token;
    logic [1:0]       tok_ctrl;
    logic [7:0]       q_fix;
    logic [7:0]       dec_byte;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_next;
    logic             seen;
    logic             seen_next;
    logic [3:0]       offset_next;
    logic             run_hit;
    logic             win_end;
    logic             slip;

    // Stage 1: input register plus the previous word, giving a 20-bit window of the wire.
    always_ff @(posedge clk_pixel or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            raw_reg  <= '0;
            prev_raw <= '0;
        end else begin
            raw_reg  <= tmds_raw;
            prev_raw <= raw_reg;
        end
    end

    assign sel_buf = {raw_reg, prev_raw};

    // Bit 0 is first on the wire, so the older word sits in the low half of the buffer.
    always_comb begin
        aligned = sel_buf[9:0];
        for (int k = 1; k < 10; k++) begin
            if (offset == 4'(k)) aligned = sel_buf[k +: 10];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        is_token = 1'b1;
        tok_ctrl = 2'b00;
        case (aligned)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    always_comb begin
        q_fix       = aligned[9] ? ~aligned[7:0] : aligned[7:0];
        dec_byte    = '0;
        dec_byte[0] = q_fix[0];
        for (int i = 1; i < 8; i++) begin
            dec_byte[i] = aligned[8] ? (q_fix[i] ^ q_fix[i-1]) : ~(q_fix[i] ^ q_fix[i-1]);
        end
    end

    // A hit is a token that completes (or extends) a run of at least C_run tokens.
    assign run_hit = is_token && (run_cnt >= RUN_LAST);
    assign win_end = (win_cnt == WIN_LAST);

    always_comb begin
        state_next  = state;
        offset_next = offset;
        win_next    = win_end ? '0 : win_cnt + WIN_ONE;
        seen_next   = seen;
        slip        = 1'b0;

        if (!is_token)           run_next = '0;
        else if (run_cnt < RUN_MAX) run_next = run_cnt + RUN_ONE;
        else                     run_next = run_cnt;

        case (state)
            SEARCH: begin
                if (run_hit) begin
                    state_next = LOCKED;
                    win_next   = '0;
                    seen_next  = 1'b0;
                end else if (win_end) begin
                    slip = 1'b1;
                end
            end
            LOCKED: begin
                if (run_hit) seen_next = 1'b1;
                if (win_end) begin
                    if (seen || run_hit) begin
                        seen_next = 1'b0;
                    end else begin
                        slip       = 1'b1;
                        state_next = SEARCH;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase

        // A slip restarts the hunt at the next bit phase with fresh run and window counts.
        if (slip) begin
            offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            run_next    = '0;
            win_next    = '0;
            seen_next   = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state   <= SEARCH;
            offset  <= 4'd0;
            run_cnt <= '0;
            win_cnt <= '0;
            seen    <= 1'b0;
        end else begin
            state   <= state_next;
            offset  <= offset_next;
            run_cnt <= run_next;
            win_cnt <= win_next;
            seen    <= seen_next;
        end
    end

    // Stage 2: registered decode; data and control bits hold across the other symbol kind.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            data  <= 8'h00;
            c0    <= 1'b0;
            c1    <= 1'b0;
            blank <= 1'b1;
        end else begin
            blank <= is_token;
            if (is_token) begin
                c0 <= tok_ctrl[0];
                c1 <= tok_ctrl[1];
            end else begin
                data <= dec_byte;
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef TMDS_DECODER_RELOCK_COUNT_EN
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            relock_count <= 8'd0;
        end else if (state == LOCKED && state_next == SEARCH && relock_count != 8'hFF) begin
            relock_count <= relock_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Self-checking bench for tmds_decoder_align: vector table, directed lock/slip/reset sequences,
// and randomized video-like traffic checked every cycle against a bit-stream reference model.
module tb_tmds_decoder_align;

    localparam int         C_RUN = 16;
    localparam int         C_WIN = 2048;
    localparam logic [9:0] TOK0  = 10'b1101010100;

    typedef struct {
        logic [9:0] raw;
        logic [7:0] data;
        logic       c1;
        logic       c0;
        logic       blank;
    } vec_t;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] tmds_raw;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       blank;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
    logic [7:0] relock_count;
`endif

    tmds_decoder_align #(.C_run(C_RUN), .C_window(C_WIN)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .tmds_raw  (tmds_raw),
        .data      (data),
        .c0        (c0),
        .c1        (c1),
        .blank     (blank),
        .locked    (locked),
        .offset    (offset)
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
        ,
        .relock_count (relock_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: the wire is a flat bit stream; the model keeps the last two words seen,
    // picks ten bits at the current phase and applies the lock/slip rules with plain integers.
    int m_h1, m_h2, m_off, m_run, m_win, m_data, m_relock;
    bit m_locked, m_seen, m_blank, m_c0, m_c1;
    int enc_disp;

    function automatic int token_code(input int w);
        case (w)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int ref_decode(input int q);
        int qp, d;
        qp = q[9] ? (~q & 'hFF) : (q & 'hFF);
        d  = qp ^ ((qp << 1) & 'hFF);
        if (!q[8]) d = d ^ 'hFE;
        return d;
    endfunction

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_off = 0; m_run = 0; m_win = 0; m_relock = 0;
        m_locked = 0; m_seen = 0; m_blank = 1; m_c0 = 0; m_c1 = 0; m_data = 0;
    endtask

    task automatic model_edge(input int w);
        int  sel, code, run_now;
        bit  expire, good, do_slip;
        sel  = (((m_h1 << 10) | m_h2) >> m_off) & 'h3FF;
        code = token_code(sel);
        if (code >= 0) begin
            m_blank = 1; m_c1 = code[1]; m_c0 = code[0];
        end else begin
            m_blank = 0; m_data = ref_decode(sel);
        end
        run_now = (code >= 0) ? ((m_run + 1 > C_RUN) ? C_RUN : m_run + 1) : 0;
        good    = (code >= 0) && (run_now == C_RUN);
        expire  = (m_win == C_WIN - 1);
        do_slip = 0;
        m_run   = run_now;
        m_win   = expire ? 0 : m_win + 1;
        if (!m_locked) begin
            if (good) begin
                m_locked = 1; m_win = 0; m_seen = 0;
            end else if (expire) begin
                do_slip = 1;
            end
        end else begin
            m_seen = m_seen | good;
            if (expire) begin
                if (m_seen) m_seen = 0;
                else begin
                    do_slip = 1; m_locked = 0;
                    if (m_relock < 255) m_relock++;
                end
            end
        end
        if (do_slip) begin
            m_off = (m_off + 1) % 10; m_run = 0; m_win = 0; m_seen = 0;
        end
        m_h2 = m_h1;
        m_h1 = w;
    endtask

    task automatic compare_model();
        logic [15:0] act, exp;
        act = {locked, offset, blank, c1, c0, (m_blank ? 8'h00 : data)};
        exp = {m_locked, 4'(m_off), m_blank, m_c1, m_c0, (m_blank ? 8'h00 : 8'(m_data))};
        check("model", 32'(act), 32'(exp));
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
        check("model_relock", 32'(relock_count), 32'(m_relock));
`endif
    endtask

    // Called at a falling edge: drive, clock, advance the model, compare at the next falling edge.
    task automatic step(input logic [9:0] w);
        tmds_raw = w;
        @(posedge clk_pixel);
        cyc++;
        model_edge(int'(w));
        @(negedge clk_pixel);
        compare_model();
    endtask

    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1d, n1, n0;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (enc_disp == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_disp += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((enc_disp > 0 && n1 > n0) || (enc_disp < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += (qm[8] ? 0 : -2) + n1 - n0;
        end
    endtask

    function automatic logic [9:0] rot(input logic [9:0] t, input int r);
        logic [9:0] w;
        for (int b = 0; b < 10; b++) w[b] = t[(b - r + 10) % 10];
        return w;
    endfunction

    task automatic apply_reset(input logic [9:0] hold);
        reset    = 1'b1;
        tmds_raw = hold;
        model_reset();
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        cyc   = 0;
    endtask

    vec_t       vecs[10];
    logic [9:0] toks[4];

    initial begin
        logic [9:0] w;
        int         lock_cyc;

        vecs[0] = '{10'h354, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{10'h0AB, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{10'h154, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{10'h2AB, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{10'h100, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{10'h0FF, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{10'h3FF, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{10'h155, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{10'h055, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{10'h2AA, 8'h01, 1'b1, 1'b1, 1'b0};
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

        reset    = 1'b1;
        tmds_raw = '0;
        enc_disp = 0;
        model_reset();
        #1;
        check("rst_data",   32'(data),   32'h00);
        check("rst_c",      32'({c1, c0}), 32'h0);
        check("rst_blank",  32'(blank),  32'h1);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_offset", 32'(offset), 32'h0);
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
        check("rst_relock", 32'(relock_count), 32'h0);
`endif

        // Aligned token stream at offset 0: lock two cycles after the 16th token is registered.
        apply_reset(TOK0);
        for (int i = 1; i <= 160; i++) begin
            step(TOK0);
            if (i == C_RUN + 1) check("lock_early", 32'(locked), 32'h0);
            if (i == C_RUN + 2) begin
                check("lock_rise", 32'(locked), 32'h1);
                check("lock_off0", 32'(offset), 32'h0);
            end
            if (i >= 3) check("tok_ctrl", 32'({blank, c1, c0}), 32'h4);
        end

        // Data ramp: every encoded byte comes back two cycles after it is registered.
        for (int i = 0; i < 258; i++) begin
            if (i < 256) encode(8'(i), w);
            else         w = TOK0;
            step(w);
            if (i >= 2) begin
                check("ramp_data",  32'(data),  32'(i - 2));
                check("ramp_blank", 32'(blank), 32'h0);
            end
        end

        // Vector table, each word held long enough to reach the outputs.
        for (int i = 0; i < 20; i++) step(TOK0);
        for (int i = 0; i < 10; i++) begin
            repeat (3) step(vecs[i].raw);
            check("vec_blank", 32'(blank), 32'(vecs[i].blank));
            check("vec_ctrl",  32'({c1, c0}), 32'({vecs[i].c1, vecs[i].c0}));
            if (!vecs[i].blank) check("vec_data", 32'(data), 32'(vecs[i].data));
        end

        // Back-to-back tokens 11 then 01.
        step(10'h2AB);
        step(10'h0AB);
        step(TOK0);
        check("tok11", 32'({blank, c1, c0}), 32'h7);
        step(TOK0);
        check("tok01", 32'({blank, c1, c0}), 32'h5);

        // Random video-like lines: a blanking run of mixed tokens, then encoded random pixels.
        for (int line = 0; line < 12; line++) begin
            int ntok;
            ntok = $urandom_range(20, 60);
            for (int i = 0; i < ntok; i++) step(toks[$urandom_range(0, 3)]);
            for (int i = 0; i < 180; i++) begin
                encode(8'($urandom_range(0, 255)), w);
                step(w);
            end
        end
        check("video_locked", 32'(locked), 32'h1);

        // Tokens stop: lock must drop at a window expiry and the phase slips to 1.
        lock_cyc = -1;
        for (int i = 1; i <= 2 * C_WIN + 8; i++) begin
            encode(8'($urandom_range(0, 255)), w);
            step(w);
            if (!locked) begin
                lock_cyc = i;
                break;
            end
        end
        check("loss_seen",   32'(lock_cyc > C_WIN), 32'h1);
        check("loss_offset", 32'(offset), 32'h1);
`ifdef TMDS_DECODER_RELOCK_COUNT_EN
        check("loss_relock", 32'(relock_count), 32'h1);
`endif

        // Stream rotated by 3 bits: three slips, then lock at offset 3.
        apply_reset(rot(TOK0, 3));
        lock_cyc = -1;
        for (int i = 1; i <= 3 * C_WIN + C_RUN + 2; i++) begin
            step(rot(TOK0, 3));
            if (i == C_WIN - 1) check("rot_off0", 32'(offset), 32'h0);
            if (i == C_WIN)     check("rot_off1", 32'(offset), 32'h1);
            if (i == 2 * C_WIN) check("rot_off2", 32'(offset), 32'h2);
            if (i == 3 * C_WIN) check("rot_off3", 32'(offset), 32'h3);
            if (locked) begin
                lock_cyc = i;
                break;
            end
        end
        check("rot_locked", 32'(locked), 32'h1);
        check("rot_offset", 32'(offset), 32'h3);
        check("rot_in_time", 32'(lock_cyc >= 0 && lock_cyc <= 3 * C_WIN + C_RUN + 2), 32'h1);

        // Lock at offset 5, then an asynchronous reset pulse mid-cycle.
        apply_reset(rot(TOK0, 5));
        for (int i = 1; i <= 5 * C_WIN + C_RUN + 2; i++) begin
            step(rot(TOK0, 5));
            if (locked) break;
        end
        check("off5_locked", 32'(locked), 32'h1);
        check("off5_offset", 32'(offset), 32'h5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_locked", 32'(locked), 32'h0);
        check("arst_offset", 32'(offset), 32'h0);
        check("arst_blank",  32'(blank),  32'h1);
        check("arst_data",   32'(data),   32'h00);
        @(negedge clk_pixel);
        apply_reset(TOK0);
        for (int i = 1; i <= C_RUN + 4; i++) begin
            step(TOK0);
            if (i == C_RUN + 1) check("relock_early", 32'(locked), 32'h0);
            if (i == C_RUN + 2) begin
                check("relock_rise", 32'(locked), 32'h1);
                check("relock_off0", 32'(offset), 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tmds_decoder_align.md
# tmds_decoder_align

Receive-side counterpart of the DVI/HDMI output path: takes one raw 10-bit TMDS word per pixel clock from a deserializer running at an arbitrary bit phase, finds the correct 10-bit word boundary by hunting for control tokens, and decodes the aligned symbols back into 8-bit pixel data, two control bits and blank. One instance serves one TMDS channel. Channel 0 (blue) control bits carry hsync and vsync. Outputs feed VGA-style consumers in the clk_pixel domain.

## Interface
Parameters:
- C_run, 16: consecutive control tokens needed to declare lock.
- C_window, 2048: symbols per supervision window; must exceed one video line.

Ports:
- clk_pixel  in  1  pixel clock; one TMDS word per cycle.
- reset  in  1  asynchronous, active-high reset.
- tmds_raw  in  10  raw deserialized word; bit 0 is first on the wire.
- data  out  8  decoded pixel byte; valid when blank=0.
- c0  out  1  control bit 0 (hsync on channel 0).
- c1  out  1  control bit 1 (vsync on channel 0).
- blank  out  1  1 while the current symbol is a control token.
- locked  out  1  word alignment established.
- offset  out  4  current bit-slip offset, 0..9.

## Operation
- Buffer: keep the previous raw word. Form buf = {tmds_raw_reg, prev_raw}, 20 bits. The aligned word is buf[offset+9:offset].
- Control tokens, aligned word value to {c1,c0}:
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- Data decode for any non-token word q:
  - q' = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = q'[0].
  - For i = 1..7: d[i] = q'[i] ^ q'[i-1] when q[8]=1, else ~(q'[i] ^ q'[i-1]).
  - Data symbols set blank=0. c0 and c1 hold their last token values.
- run counter: increments on each token and clears on any non-token. It saturates at C_run.
- window counter: counts 0..C_window-1 and wraps.
- FSM SEARCH: run reaching C_run -> LOCKED, which clears the window counter. Window expiry without a lock -> offset = (offset+1) mod 10 (9 wraps to 0), and run and window are cleared.
- FSM LOCKED: locked=1. Each window must contain at least one run of C_run tokens. If a window expires with no such run -> SEARCH, locked=0, and offset increments the same way.
- Simultaneous events: run reaching C_run on the same cycle the window expires counts as success. In SEARCH this locks; in LOCKED it keeps lock. No slip occurs.
- After a slip, the run counter restarts from 0 on the next aligned word.
- Decode outputs run in every state. Consumers must gate them with locked.

## Timing
- Latency: tmds_raw to data/c0/c1/blank is 2 clk_pixel cycles.
  - Stage 1: input register.
  - Stage 2: select and decode, registered.
- locked rises 2 cycles after the C_run-th consecutive aligned token enters at stage 1.
- A slip takes effect on the select of the very next cycle.
- Reset values, asynchronous: data=0, c0=0, c1=0, blank=1, locked=0, offset=0. The FSM enters SEARCH and all counters and buffers clear.
- Reset asserted mid-lock drops locked within the same cycle. Re-acquisition after release restarts from offset 0.

## Configuration
- Macro `TMDS_DECODER_RELOCK_COUNT_EN`.
- Defined: adds output port relock_count [7:0]. It is an 8-bit saturating count (sticks at 255) of LOCKED->SEARCH transitions. Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Aligned stream at offset 0: 160 tokens 1101010100, then a data ramp. Expect:
  - locked=1 two cycles after token 16;
  - offset=0;
  - blank=1, c0=0, c1=0 during the tokens.
- Same stream rotated by 3 bits. Expect:
  - offset steps 0->1->2->3 at each 2048-cycle window expiry;
  - locked=1 with offset=3 no later than 3*2048+16+2 cycles.
- Locked; 256 data symbols from the team's TMDS encoder model for bytes 0x00..0xFF. Expect:
  - data equals each byte exactly 2 cycles after input;
  - blank=0.
- Locked; token 1010101011, then 0010101011. Expect c1=1/c0=1, then c1=0/c0=1, with blank=1 both cycles.
- Locked; 2048 consecutive data symbols, then no tokens. Expect:
  - locked falls at window expiry;
  - offset becomes 1;
  - relock_count increments to 1 when the macro is defined.
- Reset pulse while locked at offset 5. Expect immediately: locked=0, offset=0, blank=1, data=0. Lock is re-acquired normally after release.
